// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: hazard controller state encoding, register index width
// and the canonical NOP that IF/ID flush consumers load.
package pipe_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam logic [31:0] NOP_INST   = 32'h00000013;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    MEM_WAIT   = 2'd2
  } hz_state_t;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use detector: EX holds a load whose destination the ID
// instruction actually reads (x0 never creates a dependency).
module load_use_detect #(
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] rs1_id,
  input  logic [REG_ADDR_W-1:0] rs2_id,
  input  logic                  use_rs1_id,
  input  logic                  use_rs2_id,
  input  logic [REG_ADDR_W-1:0] rd_ex,
  input  logic                  MemRead_ex,
  output logic                  load_use
);

  assign load_use = MemRead_ex && (rd_ex != {REG_ADDR_W{1'b0}}) &&
                    ((use_rs1_id && (rd_ex == rs1_id)) ||
                     (use_rs2_id && (rd_ex == rs2_id)));

endmodule

// File: rtl/hazard_control.sv
// Pipeline hazard/stall controller: memory freeze, branch flush, one-bubble load-use stall.
// Optional performance counters are enabled by defining HAZARD_PERF_CNT_EN.
module hazard_control
  import pipe_pkg::*;
#(
  parameter int unsigned REG_ADDR_W   = pipe_pkg::REG_ADDR_W,
`ifdef HAZARD_PERF_CNT_EN
  parameter int unsigned CNT_W        = 32,
`endif
  parameter int unsigned MEM_WAIT_MAX = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] rs1_id,
  input  logic [REG_ADDR_W-1:0] rs2_id,
  input  logic                  use_rs1_id,
  input  logic                  use_rs2_id,
  input  logic [REG_ADDR_W-1:0] rd_ex,
  input  logic                  MemRead_ex,
  input  logic                  branch_taken_ex,
  input  logic                  mem_busy,
`ifdef HAZARD_PERF_CNT_EN
  output logic [CNT_W-1:0]      stall_cycles,
  output logic [CNT_W-1:0]      flush_count,
  output logic [CNT_W-1:0]      load_use_count,
`endif
  output logic                  PCWrite,
  output logic                  IF_ID_Write,
  output logic                  IF_ID_flush,
  output logic                  ID_EX_bubble,
  output logic                  EX_MEM_Write,
  output logic                  mem_timeout
);

  localparam int unsigned WAIT_W = $clog2(MEM_WAIT_MAX + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_WAIT_MAX);

  hz_state_t         state, next_state;
  logic              load_use;
  logic [WAIT_W-1:0] wait_cnt, wait_cnt_next;
  logic              timeout_r;

  load_use_detect #(.REG_ADDR_W(REG_ADDR_W)) u_lud (
    .rs1_id     (rs1_id),
    .rs2_id     (rs2_id),
    .use_rs1_id (use_rs1_id),
    .use_rs2_id (use_rs2_id),
    .rd_ex      (rd_ex),
    .MemRead_ex (MemRead_ex),
    .load_use   (load_use)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RUN;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; memory freeze outranks branch, branch outranks load-use
  always_comb begin
    next_state = RUN;
    if (mem_busy) begin
      next_state = MEM_WAIT;
    end else if (branch_taken_ex) begin
      next_state = RUN;
    end else if (load_use && (state != LOAD_STALL)) begin
      next_state = LOAD_STALL;
    end else begin
      next_state = RUN;
    end
  end

  // Mealy outputs; reset forces the flush/bubble safe values asynchronously
  always_comb begin
    PCWrite      = 1'b1;
    IF_ID_Write  = 1'b1;
    IF_ID_flush  = 1'b0;
    ID_EX_bubble = 1'b0;
    EX_MEM_Write = 1'b1;
    if (reset) begin
      PCWrite      = 1'b0;
      IF_ID_Write  = 1'b0;
      IF_ID_flush  = 1'b1;
      ID_EX_bubble = 1'b1;
      EX_MEM_Write = 1'b0;
    end else if (mem_busy) begin
      PCWrite      = 1'b0;
      IF_ID_Write  = 1'b0;
      EX_MEM_Write = 1'b0;
    end else if (branch_taken_ex) begin
      IF_ID_flush  = 1'b1;
      ID_EX_bubble = 1'b1;
    end else if (load_use && (state != LOAD_STALL)) begin
      PCWrite      = 1'b0;
      IF_ID_Write  = 1'b0;
      ID_EX_bubble = 1'b1;
    end else begin
      PCWrite      = 1'b1;
    end
  end

  // Busy-cycle count; counting starts on the cycle that enters MEM_WAIT, so it is zero elsewhere
  always_comb begin
    wait_cnt_next = {WAIT_W{1'b0}};
    if (mem_busy) begin
      wait_cnt_next = (wait_cnt == WAIT_MAX) ? WAIT_MAX : wait_cnt + WAIT_W'(1);
    end else begin
      wait_cnt_next = {WAIT_W{1'b0}};
    end
  end

  // Wait counter and sticky timeout flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt  <= {WAIT_W{1'b0}};
      timeout_r <= 1'b0;
    end else begin
      wait_cnt <= wait_cnt_next;
      if (wait_cnt_next == WAIT_MAX) begin
        timeout_r <= 1'b1;
      end
    end
  end

  assign mem_timeout = timeout_r;

`ifdef HAZARD_PERF_CNT_EN
  // Performance counters, wrapping modulo 2^CNT_W
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles   <= {CNT_W{1'b0}};
      flush_count    <= {CNT_W{1'b0}};
      load_use_count <= {CNT_W{1'b0}};
    end else begin
      if (!PCWrite) begin
        stall_cycles <= stall_cycles + CNT_W'(1);
      end
      if (IF_ID_flush) begin
        flush_count <= flush_count + CNT_W'(1);
      end
      if ((next_state == LOAD_STALL) && (state != LOAD_STALL)) begin
        load_use_count <= load_use_count + CNT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_hazard_control.sv
// Self-checking bench for hazard_control: directed hazard scenarios then randomized
// traffic, all checked against a cycle-level model of the hazard rules.
module tb_hazard_control;

  localparam int W = 5;
  localparam int WAIT_MAX = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] rs1_id, rs2_id, rd_ex;
  logic         use_rs1_id, use_rs2_id, MemRead_ex, branch_taken_ex, mem_busy;
  logic         PCWrite, IF_ID_Write, IF_ID_flush, ID_EX_bubble, EX_MEM_Write, mem_timeout;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0]  stall_cycles, flush_count, load_use_count;
`endif

  hazard_control dut (
    .clk(clk), .reset(reset),
    .rs1_id(rs1_id), .rs2_id(rs2_id), .use_rs1_id(use_rs1_id), .use_rs2_id(use_rs2_id),
    .rd_ex(rd_ex), .MemRead_ex(MemRead_ex), .branch_taken_ex(branch_taken_ex),
    .mem_busy(mem_busy),
`ifdef HAZARD_PERF_CNT_EN
    .stall_cycles(stall_cycles), .flush_count(flush_count), .load_use_count(load_use_count),
`endif
    .PCWrite(PCWrite), .IF_ID_Write(IF_ID_Write), .IF_ID_flush(IF_ID_flush),
    .ID_EX_bubble(ID_EX_bubble), .EX_MEM_Write(EX_MEM_Write), .mem_timeout(mem_timeout)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: was the previous cycle the load-use bubble, length of the busy run, sticky timeout
  bit          m_after_bubble;
  int          m_busy_run;
  bit          m_timeout;
  logic [31:0] m_stall, m_flush, m_lu;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic model_clear();
    m_after_bubble = 1'b0;
    m_busy_run = 0;
    m_timeout = 1'b0;
    m_stall = 32'd0;
    m_flush = 32'd0;
    m_lu = 32'd0;
  endtask

  task automatic set_in(input bit mr, input int rd, input int r1, input int r2,
                        input bit u1, input bit u2, input bit br, input bit busy);
    MemRead_ex = mr; rd_ex = W'(rd); rs1_id = W'(r1); rs2_id = W'(r2);
    use_rs1_id = u1; use_rs2_id = u2; branch_taken_ex = br; mem_busy = busy;
  endtask

  // Evaluate one cycle: check outputs mid-cycle, then advance the model across the rising edge
  task automatic step();
    bit lu, e_pc, e_ifid, e_flush, e_bub, e_exm, e_enter;
    #1;
    lu = MemRead_ex && (rd_ex != 0) &&
         ((use_rs1_id && rd_ex == rs1_id) || (use_rs2_id && rd_ex == rs2_id));
    e_enter = 1'b0;
    if (mem_busy) begin
      {e_pc, e_ifid, e_flush, e_bub, e_exm} = 5'b00000;
    end else if (branch_taken_ex) begin
      {e_pc, e_ifid, e_flush, e_bub, e_exm} = 5'b11111;
    end else if (lu && !m_after_bubble) begin
      {e_pc, e_ifid, e_flush, e_bub, e_exm} = 5'b00011;
      e_enter = 1'b1;
    end else begin
      {e_pc, e_ifid, e_flush, e_bub, e_exm} = 5'b11001;
    end
    check_val("PCWrite", 32'(PCWrite), 32'(e_pc));
    check_val("IF_ID_Write", 32'(IF_ID_Write), 32'(e_ifid));
    check_val("IF_ID_flush", 32'(IF_ID_flush), 32'(e_flush));
    check_val("ID_EX_bubble", 32'(ID_EX_bubble), 32'(e_bub));
    check_val("EX_MEM_Write", 32'(EX_MEM_Write), 32'(e_exm));
    check_val("mem_timeout", 32'(mem_timeout), 32'(m_timeout));
`ifdef HAZARD_PERF_CNT_EN
    check_val("stall_cycles", stall_cycles, m_stall);
    check_val("flush_count", flush_count, m_flush);
    check_val("load_use_count", load_use_count, m_lu);
`endif
    @(posedge clk);
    m_after_bubble = e_enter;
    m_busy_run = mem_busy ? ((m_busy_run < WAIT_MAX) ? m_busy_run + 1 : WAIT_MAX) : 0;
    if (m_busy_run == WAIT_MAX) m_timeout = 1'b1;
    if (!e_pc) m_stall++;
    if (e_flush) m_flush++;
    if (e_enter) m_lu++;
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_PCWrite"}, 32'(PCWrite), 32'd0);
    check_val({tag, "_IF_ID_Write"}, 32'(IF_ID_Write), 32'd0);
    check_val({tag, "_IF_ID_flush"}, 32'(IF_ID_flush), 32'd1);
    check_val({tag, "_ID_EX_bubble"}, 32'(ID_EX_bubble), 32'd1);
    check_val({tag, "_EX_MEM_Write"}, 32'(EX_MEM_Write), 32'd0);
    check_val({tag, "_mem_timeout"}, 32'(mem_timeout), 32'd0);
`ifdef HAZARD_PERF_CNT_EN
    check_val({tag, "_counters"}, stall_cycles | flush_count | load_use_count, 32'd0);
`endif
  endtask

  // Reset asserted away from the clock edge; outputs must respond before any edge
  task automatic do_reset(input string tag);
    #2 reset = 1'b1;
    #1 check_reset_outputs(tag);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_clear();
  endtask

  initial begin
    reset = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    model_clear();
    #1 check_reset_outputs("por");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // ld x5 then dependent add: one bubble, then advance despite unchanged inputs
    set_in(1, 5, 5, 0, 1, 0, 0, 0);
    step();
    step();
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    step();

    // x0 destination and unused rs2 never stall
    set_in(1, 0, 0, 0, 1, 1, 0, 0);
    step();
    set_in(1, 7, 1, 7, 1, 0, 0, 0);
    step();
    set_in(1, 9, 2, 9, 0, 1, 0, 0);
    step();
    step();

    // branch beats load-use; next cycle load-use is evaluated from RUN
    set_in(1, 5, 5, 0, 1, 0, 1, 0);
    step();
    set_in(1, 5, 5, 0, 1, 0, 0, 0);
    step();
    step();

    // memory busy during load-use: freeze, then bubble, then advance
    repeat (3) begin set_in(1, 5, 5, 0, 1, 0, 0, 1); step(); end
    set_in(1, 5, 5, 0, 1, 0, 0, 0);
    step();
    step();

    // 16 busy cycles set the sticky timeout, which survives until reset
    repeat (WAIT_MAX) begin set_in(0, 0, 0, 0, 0, 0, 0, 1); step(); end
    check_val("timeout_after_16", 32'(mem_timeout), 32'd1);
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) step();
    do_reset("timeout_clr");
    step();

    // 15 busy cycles must not time out
    repeat (WAIT_MAX - 1) begin set_in(1, 3, 3, 3, 1, 1, 0, 1); step(); end
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    step();
    check_val("no_timeout_15", 32'(mem_timeout), 32'd0);

    // asynchronous reset mid-MEM_WAIT
    repeat (4) begin set_in(0, 0, 0, 0, 0, 0, 0, 1); step(); end
    do_reset("midwait");
    set_in(1, 4, 4, 0, 1, 0, 0, 0);
    step();
    step();

    // randomized traffic with small register indices to provoke hazards
    for (int i = 0; i < 800; i++) begin
      set_in($urandom_range(0, 1) == 1, $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 3), $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
             $urandom_range(0, 5) == 0, $urandom_range(0, 6) == 0);
      if ($urandom_range(0, 99) == 0) begin
        for (int k = 0; k < $urandom_range(10, 20); k++) begin
          mem_busy = 1'b1;
          step();
        end
      end else if ($urandom_range(0, 199) == 0) begin
        do_reset("rand_rst");
      end else begin
        step();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/hazard_control.md
Name: hazard_control

Overview:
Pipeline hazard and stall controller for the 5-stage RV64 pipeline. It is the counterpart of the EX-stage forwarding unit: forwarding consumes in-flight MEM/WB results, and this block detects the cases forwarding cannot cover. Those cases are load-use, taken-branch redirect and multi-cycle data-memory busy. For each it drives PC / pipeline-register write enables and bubble/flush controls. It sits beside the ID stage, observing ID and EX stage fields.

Parameters:
REG_ADDR_W, 5, register index width
MEM_WAIT_MAX, 16, consecutive mem_busy cycles before timeout flag
CNT_W, 32, width of performance counters (optional feature only)

Ports:
clk  input  1  pipeline clock, rising edge
reset  input  1  asynchronous, active-high
rs1_id  input  REG_ADDR_W  rs1 of instruction in ID
rs2_id  input  REG_ADDR_W  rs2 of instruction in ID
use_rs1_id  input  1  ID instruction reads rs1
use_rs2_id  input  1  ID instruction reads rs2
rd_ex  input  REG_ADDR_W  destination of instruction in EX
MemRead_ex  input  1  EX instruction is a load
branch_taken_ex  input  1  Branch_ex AND ALU zero: redirect PC
mem_busy  input  1  data memory not ready this cycle
PCWrite  output  1  PC register load enable
IF_ID_Write  output  1  IF/ID register load enable
IF_ID_flush  output  1  clear IF/ID to NOP
ID_EX_bubble  output  1  zero ID/EX control fields (RegWrite, MemRead, MemWrite, Branch)
EX_MEM_Write  output  1  EX/MEM and MEM/WB load enable
mem_timeout  output  1  sticky: mem_busy exceeded MEM_WAIT_MAX

Behaviour:
- Interface: one clock; reset is asynchronous and active-high; ports named clk and reset.
- States: RUN, LOAD_STALL, MEM_WAIT (2-bit encoding, state is a package enum).
- Outputs are Mealy: combinational from state and current inputs. State and counters update on the rising clk edge.
- load_use = MemRead_ex & (rd_ex != 0) & ((use_rs1_id & rd_ex == rs1_id) | (use_rs2_id & rd_ex == rs2_id)).
- Priority, highest first:
  - reset: PCWrite=IF_ID_Write=EX_MEM_Write=0; IF_ID_flush=ID_EX_bubble=1; mem_timeout=0; state RUN.
  - mem_busy=1 (any state): freeze. PCWrite=IF_ID_Write=EX_MEM_Write=0, no flush, no bubble. branch_taken_ex and load_use are ignored, because the EX instruction is held and re-presents them. Next state MEM_WAIT.
  - branch_taken_ex=1: PCWrite=1, IF_ID_Write=1, IF_ID_flush=1, ID_EX_bubble=1, EX_MEM_Write=1. Next state RUN. Branch beats load_use in the same cycle, since the ID instruction is squashed anyway.
  - load_use=1 and state != LOAD_STALL: PCWrite=0, IF_ID_Write=0, ID_EX_bubble=1, EX_MEM_Write=1. Next state LOAD_STALL. This is exactly one bubble; after it, the load sits in MEM and EX forwarding from ALU_result_mem/Result_wb covers the dependency.
  - Otherwise: all write enables 1, flush/bubble 0. Next state RUN.
- LOAD_STALL lasts exactly one cycle. In it, load_use is not re-evaluated (the bubble is now in EX), so the pipeline always advances. Next state RUN unless mem_busy or branch_taken_ex applies.
- MEM_WAIT: wait_cnt increments on each cycle with mem_busy=1, saturating at MEM_WAIT_MAX.
  - When wait_cnt reaches MEM_WAIT_MAX, mem_timeout is set and stays set until reset.
  - On the first cycle with mem_busy=0, RUN rules apply to the outputs in that same cycle. wait_cnt clears and the next state is determined by those rules.
- wait_cnt width is clog2(MEM_WAIT_MAX+1). It is cleared outside MEM_WAIT.
- Reset asserted mid-stall: outputs take reset values immediately (asynchronous). State RUN on deassert.
- The first edge after deassert behaves as RUN.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- Defined: adds outputs stall_cycles, flush_count and load_use_count, each CNT_W bits, reset to 0, wrapping modulo 2^CNT_W.
  - stall_cycles increments on each cycle with PCWrite=0.
  - flush_count increments on each cycle with IF_ID_flush=1 while not in reset.
  - load_use_count increments on entry to LOAD_STALL.
- Undefined: no counters and no extra ports; the remaining behaviour is identical.

Decomposition:
- Shared package pipe_pkg holds:
  - hz_state_t enum (RUN, LOAD_STALL, MEM_WAIT)
  - REG_ADDR_W
  - NOP_INST (32'h00000013), used by IF_ID_flush consumers
- One sub-module, load_use_detect: purely combinational compare producing load_use. It is reused by the single-cycle verification model.

Test Plan:
- ld x5 in EX (MemRead_ex=1, rd_ex=5), ID add reads rs1=5 with use_rs1_id=1 -> cycle 0: PCWrite=0, IF_ID_Write=0, ID_EX_bubble=1; cycle 1 (LOAD_STALL): all enables 1, no bubble even though inputs are unchanged.
- rd_ex=0 with MemRead_ex=1 and rs1_id=0 -> no stall; also use_rs2_id=0 with a rs2 match -> no stall.
- branch_taken_ex=1 and load_use=1 in the same cycle -> PCWrite=1, IF_ID_flush=1, ID_EX_bubble=1, state stays RUN.
- mem_busy high 3 cycles during a load_use -> 3 frozen cycles with all enables 0; then load-use stall, then LOAD_STALL; mem_timeout stays 0.
- mem_busy high 16 cycles (MEM_WAIT_MAX=16) -> mem_timeout=1 from the 16th cycle. It stays 1 after mem_busy drops and clears only on reset pulse.
- reset pulsed asynchronously mid-MEM_WAIT -> immediate IF_ID_flush=1, PCWrite=0. After release: RUN; with HAZARD_PERF_CNT_EN, all counters read 0.
